fetch_sequencer: RTL and testbench

- Controls the program counter register and the instruction-memory fetch port.
- Decides each cycle whether the PC is written and with what value: reset vector, sequential increment, branch redirect or trap vector.
- Issues one outstanding fetch at a time and buffers the returned instruction for the decode stage with a valid/stall handshake.
- Sits between the PC register, instruction memory and decode; the PC register stays a plain enable-load register driven by this block.

---
 rtl/const_pkg.sv | 26 ++
 rtl/fetch_sequencer.sv | 149 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/const_pkg.sv
// -----------------------------------------------------------------------------
// const_pkg
// Shared core constants: datapath widths, the fetch sequencer state encoding,
// default reset/trap vectors and a PC word-alignment helper.
// -----------------------------------------------------------------------------
package const_pkg;

   localparam int REG_WIDTH   = 32;
   localparam int INSTR_WIDTH = 32;

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DRAIN = 2'd3
   } fetch_state_t;

   localparam logic [REG_WIDTH-1:0] DEF_RESET_VECTOR = 32'h0000_0000;
   localparam logic [REG_WIDTH-1:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

   // Force a target onto a word boundary by clearing the two low bits.
   function automatic logic [REG_WIDTH-1:0] align_word(input logic [REG_WIDTH-1:0] pc);
      return pc & ~REG_WIDTH'(3);
   endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Drives the PC register (enable + load data) and the instruction-memory fetch
// port, keeping one fetch outstanding and holding the returned instruction in
// a single-entry buffer for decode.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-low reset
//   i_pc              current PC register value
//   o_pc_we/o_pc_wdata PC register load enable / data (combinational)
//   o_imem_req/addr   single-cycle fetch request, address = i_pc
//   i_imem_ack/data   response for the outstanding request
//   o_instr_valid/o_instr/o_instr_pc  buffered instruction for decode
//   i_stall           decode cannot take the buffer this cycle
//   i_redirect/_pc    branch/jump redirect request and target
//   i_trap            trap request (wins over redirect)
//   o_flush           registered pulse the cycle after a redirect/trap
// -----------------------------------------------------------------------------
module fetch_sequencer
   import const_pkg::*;
#(
   parameter logic [REG_WIDTH-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
   parameter logic [REG_WIDTH-1:0] TRAP_VECTOR  = DEF_TRAP_VECTOR,
   parameter int                   INSTR_BYTES  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [REG_WIDTH-1:0]   i_pc,
   output logic                   o_pc_we,
   output logic [REG_WIDTH-1:0]   o_pc_wdata,
   output logic                   o_imem_req,
   output logic [REG_WIDTH-1:0]   o_imem_addr,
   input  logic                   i_imem_ack,
   input  logic [INSTR_WIDTH-1:0] i_imem_data,
   output logic                   o_instr_valid,
   output logic [INSTR_WIDTH-1:0] o_instr,
   output logic [REG_WIDTH-1:0]   o_instr_pc,
   input  logic                   i_stall,
   input  logic                   i_redirect,
   input  logic [REG_WIDTH-1:0]   i_redirect_pc,
   input  logic                   i_trap,
   output logic                   o_flush
);

   fetch_state_t           r_state;
   logic                   r_valid;
   logic [INSTR_WIDTH-1:0] r_instr;
   logic [REG_WIDTH-1:0]   r_instr_pc;
   logic                   r_flush;

   fetch_state_t           w_next;
   logic                   w_pc_we;
   logic [REG_WIDTH-1:0]   w_pc_wdata;
   logic                   w_req;
   logic                   w_take;    // redirect/trap accepted this cycle
   logic                   w_load;    // ack data goes into the buffer
   logic                   w_consume;
   logic                   w_free;
   logic                   w_ctl;
   logic [REG_WIDTH-1:0]   w_target;

   assign w_consume = r_valid & ~i_stall;
   // A slot freed by decode this cycle can already be refilled by a new fetch.
   assign w_free    = ~r_valid | w_consume;
   assign w_ctl     = i_trap | i_redirect;
   assign w_target  = i_trap ? TRAP_VECTOR : align_word(i_redirect_pc);

   always_comb begin
      w_next     = r_state;
      w_pc_we    = 1'b0;
      w_pc_wdata = '0;
      w_req      = 1'b0;
      w_take     = 1'b0;
      w_load     = 1'b0;
      // While reset is held nothing leaves the block; state is reloaded in the
      // sequential block.
      if (rst) begin
         case (r_state)
            S_BOOT: begin
               w_pc_we    = 1'b1;
               w_pc_wdata = RESET_VECTOR;
               w_next     = S_ISSUE;
            end
            S_ISSUE: begin
               if (w_ctl) begin
                  w_take = 1'b1;
               end else if (w_free) begin
                  w_req  = 1'b1;
                  w_next = S_WAIT;
               end
            end
            S_WAIT: begin
               if (w_ctl) begin
                  w_take = 1'b1;
                  // A response arriving with the redirect retires the request;
                  // otherwise it is still in flight and must be drained.
                  w_next = i_imem_ack ? S_ISSUE : S_DRAIN;
               end else if (i_imem_ack) begin
                  w_load     = 1'b1;
                  w_pc_we    = 1'b1;
                  w_pc_wdata = i_pc + REG_WIDTH'(INSTR_BYTES);
                  w_next     = S_ISSUE;
               end
            end
            S_DRAIN: begin
               if (w_ctl) w_take = 1'b1;
               if (i_imem_ack) w_next = S_ISSUE;
            end
            default: w_next = S_BOOT;
         endcase
         if (w_take) begin
            w_pc_we    = 1'b1;
            w_pc_wdata = w_target;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= S_BOOT;
         r_valid    <= 1'b0;
         r_instr    <= '0;
         r_instr_pc <= '0;
         r_flush    <= 1'b0;
      end else begin
         r_state <= w_next;
         r_flush <= w_take;
         if (w_take) begin
            r_valid <= 1'b0;
         end else if (w_load) begin
            r_valid    <= 1'b1;
            r_instr    <= i_imem_data;
            r_instr_pc <= i_pc;
         end else if (w_consume) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign o_pc_we       = w_pc_we;
   assign o_pc_wdata    = w_pc_wdata;
   assign o_imem_req    = w_req;
   assign o_imem_addr   = i_pc;
   assign o_instr_valid = r_valid;
   assign o_instr       = r_instr;
   assign o_instr_pc    = r_instr_pc;
   assign o_flush       = r_flush;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Directed stimulus with a cycle-tagged scoreboard. The stimulus process pushes
// expected events (PC write, fetch request, flush, buffer load, state
// snapshot) tagged with the cycle they must appear in; a negedge monitor pops
// and compares them and flags any unexpected event. The bench models the PC
// register that sits next to the DUT.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;
   import const_pkg::*;

   localparam int K_WE = 0, K_REQ = 1, K_FLUSH = 2, K_INSTR = 3, K_SNAP = 4;

   typedef struct {
      int          kind;
      int          cyc;
      logic [63:0] val;
   } ent_t;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [REG_WIDTH-1:0]   pc = '0;
   logic                   o_pc_we, o_imem_req, o_instr_valid, o_flush;
   logic [REG_WIDTH-1:0]   o_pc_wdata, o_imem_addr, o_instr_pc;
   logic [INSTR_WIDTH-1:0] o_instr;
   logic                   i_imem_ack, i_stall, i_redirect, i_trap;
   logic [INSTR_WIDTH-1:0] i_imem_data;
   logic [REG_WIDTH-1:0]   i_redirect_pc;

   ent_t q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   done = 1'b0;
   bit   prev_valid = 1'b0;

   fetch_sequencer #(
      .RESET_VECTOR(32'h0000_1000),
      .TRAP_VECTOR (32'h0000_0100),
      .INSTR_BYTES (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_pc         (pc),
      .o_pc_we      (o_pc_we),
      .o_pc_wdata   (o_pc_wdata),
      .o_imem_req   (o_imem_req),
      .o_imem_addr  (o_imem_addr),
      .i_imem_ack   (i_imem_ack),
      .i_imem_data  (i_imem_data),
      .o_instr_valid(o_instr_valid),
      .o_instr      (o_instr),
      .o_instr_pc   (o_instr_pc),
      .i_stall      (i_stall),
      .i_redirect   (i_redirect),
      .i_redirect_pc(i_redirect_pc),
      .i_trap       (i_trap),
      .o_flush      (o_flush)
   );

   always #5 clk = ~clk;

   // Cycle counter and the plain enable-load PC register.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (o_pc_we === 1'b1) pc <= o_pc_wdata;
   end

   function automatic string kname(input int k);
      case (k)
         K_WE:    return "pc_we";
         K_REQ:   return "imem_req";
         K_FLUSH: return "flush";
         K_INSTR: return "instr_load";
         default: return "snapshot";
      endcase
   endfunction

   function automatic logic [63:0] snap(input bit v, input bit f, input bit w,
                                        input bit r, input logic [31:0] ins);
      return {28'b0, v, f, w, r, ins};
   endfunction

   // Insert keeping the queue ordered by cycle.
   task automatic expect_ev(input int k, input int c, input logic [63:0] v);
      int i;
      ent_t e;
      e.kind = k;
      e.cyc  = c;
      e.val  = v;
      i = q.size();
      while (i > 0 && q[i-1].cyc > c) i--;
      q.insert(i, e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      bit          fired [0:4];
      bit          hit   [0:4];
      logic [63:0] act   [0:4];
      ent_t        e;
      if (cyc > 0) begin
         for (int k = 0; k < 5; k++) hit[k] = 1'b0;
         fired[K_WE]    = (o_pc_we === 1'b1);
         act[K_WE]      = {32'b0, o_pc_wdata};
         fired[K_REQ]   = (o_imem_req === 1'b1);
         act[K_REQ]     = {32'b0, o_imem_addr};
         fired[K_FLUSH] = (o_flush === 1'b1);
         act[K_FLUSH]   = 64'd1;
         fired[K_INSTR] = (o_instr_valid === 1'b1) && !prev_valid;
         act[K_INSTR]   = {o_instr, o_instr_pc};
         fired[K_SNAP]  = 1'b1;
         act[K_SNAP]    = snap(o_instr_valid, o_flush, o_pc_we, o_imem_req, o_instr);
         while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.cyc < cyc) begin
               errors++;
               $display("FAIL %s cyc %0d: never seen, required %h", kname(e.kind), e.cyc, e.val);
            end else if (!fired[e.kind]) begin
               errors++;
               $display("FAIL %s cyc %0d: not presented, required %h", kname(e.kind), cyc, e.val);
            end else begin
               hit[e.kind] = 1'b1;
               if (act[e.kind] !== e.val) begin
                  errors++;
                  $display("FAIL %s cyc %0d: got %h required %h", kname(e.kind), cyc, act[e.kind], e.val);
               end
            end
         end
         for (int k = 0; k < 4; k++) begin
            if (fired[k] && !hit[k]) begin
               checks++;
               errors++;
               $display("FAIL %s cyc %0d: unexpected event, value %h", kname(k), cyc, act[k]);
            end
         end
         prev_valid = (o_instr_valid === 1'b1);
         if (done) begin
            while (q.size() > 0) begin
               e = q.pop_front();
               checks++;
               errors++;
               $display("FAIL %s cyc %0d: never seen, required %h", kname(e.kind), e.cyc, e.val);
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
         end
      end
   end

   initial begin
      int a;
      rst = 1'b0; i_imem_ack = 1'b0; i_imem_data = '0; i_stall = 1'b0;
      i_redirect = 1'b0; i_redirect_pc = '0; i_trap = 1'b0;
      tick(); tick();
      // Reset state: nothing driven, buffer empty.
      expect_ev(K_SNAP, cyc, snap(0, 0, 0, 0, 32'h0));
      tick(); a = cyc;
      // Boot: PC loaded with the reset vector, then first fetch.
      rst = 1'b1;
      expect_ev(K_WE, a, 64'h1000);
      tick(); expect_ev(K_REQ, a+1, 64'h1000);
      tick();
      tick(); i_imem_ack = 1'b1; i_imem_data = 32'h0050_0093;        // a+3
      expect_ev(K_WE, a+3, 64'h1004);
      expect_ev(K_INSTR, a+4, {32'h0050_0093, 32'h1000});
      // Stall three cycles: buffer held, no request.
      tick(); i_imem_ack = 1'b0; i_stall = 1'b1;                      // a+4
      for (int n = 4; n < 7; n++) expect_ev(K_SNAP, a+n, snap(1, 0, 0, 0, 32'h0050_0093));
      tick(); tick();
      tick(); i_stall = 1'b0;                                         // a+7
      expect_ev(K_REQ, a+7, 64'h1004);
      // Redirect in S_WAIT to an unaligned target.
      tick(); i_redirect = 1'b1; i_redirect_pc = 32'h2002;            // a+8
      expect_ev(K_WE, a+8, 64'h2000);
      expect_ev(K_SNAP, a+8, snap(0, 0, 1, 0, 32'h0050_0093));
      expect_ev(K_FLUSH, a+9, 64'd1);
      tick(); i_redirect = 1'b0;                                      // a+9 drain
      tick(); i_imem_ack = 1'b1; i_imem_data = 32'hDEAD_BEEF;         // a+10 discarded
      expect_ev(K_SNAP, a+10, snap(0, 0, 0, 0, 32'h0050_0093));
      tick(); i_imem_ack = 1'b0;                                      // a+11
      expect_ev(K_REQ, a+11, 64'h2000);
      expect_ev(K_SNAP, a+11, snap(0, 0, 0, 1, 32'h0050_0093));
      // Trap and redirect together: trap vector wins, single flush.
      tick(); i_trap = 1'b1; i_redirect = 1'b1; i_redirect_pc = 32'h3000;  // a+12
      expect_ev(K_WE, a+12, 64'h100);
      expect_ev(K_FLUSH, a+13, 64'd1);
      tick(); i_trap = 1'b0; i_redirect = 1'b0;                       // a+13 drain + ack
      i_imem_ack = 1'b1; i_imem_data = 32'h0BAD_0BAD;
      tick(); i_imem_ack = 1'b0;                                      // a+14
      expect_ev(K_REQ, a+14, 64'h100);
      // Redirect coincident with ack: data dropped, no increment.
      tick(); i_imem_ack = 1'b1; i_imem_data = 32'h1111_1111;         // a+15
      i_redirect = 1'b1; i_redirect_pc = 32'h4000;
      expect_ev(K_WE, a+15, 64'h4000);
      expect_ev(K_FLUSH, a+16, 64'd1);
      tick(); i_imem_ack = 1'b0; i_redirect = 1'b0;                   // a+16
      expect_ev(K_REQ, a+16, 64'h4000);
      tick(); i_imem_ack = 1'b1; i_imem_data = 32'h2222_2222;         // a+17
      expect_ev(K_WE, a+17, 64'h4004);
      expect_ev(K_INSTR, a+18, {32'h2222_2222, 32'h4000});
      // Buffer consumed in the same cycle a new fetch is issued.
      tick(); i_imem_ack = 1'b0;                                      // a+18
      expect_ev(K_REQ, a+18, 64'h4004);
      // Redirect to the top word, then wrap on increment.
      tick(); i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFF;       // a+19
      expect_ev(K_WE, a+19, 64'hFFFF_FFFC);
      expect_ev(K_FLUSH, a+20, 64'd1);
      tick(); i_redirect = 1'b0; i_imem_ack = 1'b1; i_imem_data = 32'h0; // a+20 drained
      tick(); i_imem_ack = 1'b0;                                      // a+21
      expect_ev(K_REQ, a+21, 64'hFFFF_FFFC);
      tick(); i_imem_ack = 1'b1; i_imem_data = 32'h3333_3333;         // a+22
      expect_ev(K_WE, a+22, 64'h0);
      expect_ev(K_INSTR, a+23, {32'h3333_3333, 32'hFFFF_FFFC});
      tick(); i_imem_ack = 1'b0;                                      // a+23
      expect_ev(K_REQ, a+23, 64'h0);
      // Reset while a fetch is outstanding; its ack lands during boot.
      tick(); rst = 1'b0;                                             // a+24
      expect_ev(K_SNAP, a+24, snap(0, 0, 0, 0, 32'h3333_3333));
      tick(); rst = 1'b1; i_imem_ack = 1'b1; i_imem_data = 32'h4444_4444;  // a+25
      expect_ev(K_WE, a+25, 64'h1000);
      expect_ev(K_SNAP, a+25, snap(0, 0, 1, 0, 32'h0));
      tick(); i_imem_ack = 1'b0;                                      // a+26
      expect_ev(K_REQ, a+26, 64'h1000);
      expect_ev(K_SNAP, a+26, snap(0, 0, 0, 1, 32'h0));
      tick(); i_imem_ack = 1'b1; i_imem_data = 32'h5555_5555;         // a+27
      expect_ev(K_WE, a+27, 64'h1004);
      expect_ev(K_INSTR, a+28, {32'h5555_5555, 32'h1000});
      tick(); i_imem_ack = 1'b0; i_stall = 1'b1;                      // a+28
      expect_ev(K_SNAP, a+28, snap(1, 0, 0, 0, 32'h5555_5555));
      tick();
      done = 1'b1;
   end

   // Safety net in case the monitor never reaches its summary.
   initial begin
      #20000;
      $display("FAIL timeout: summary not reached, required completion");
      $fatal(1, "timeout");
   end

endmodule
